// File: rtl/tcount_sequencer_if.sv
// Handshake bundle between the A/B period sequencer and its control/counter side.
// The slave modport is the sequencer's view; the master modport is the driver's.
interface tcount_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] period_a;
    logic [7:0] period_b;
    logic [3:0] cycles;
    logic       tcount;
    logic       load;
    logic [7:0] preset;
    logic       busy;
    logic       phase;
    logic       done;
    logic       err;

    modport master (
        output start, abort, period_a, period_b, cycles, tcount,
        input  load, preset, busy, phase, done, err
    );

    modport slave (
        input  start, abort, period_a, period_b, cycles, tcount,
        output load, preset, busy, phase, done, err
    );
endinterface

// File: rtl/tcount_sequencer.sv
// Alternating A/B period sequencer driving an external loadable 8-bit up-counter,
// with a per-wait timeout that parks the block in ERROR until abort.
module tcount_sequencer #(
    parameter int TIMEOUT = 300
) (
    input  logic                 clk,
    input  logic                 reset,
    tcount_sequencer_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_WAIT_A,
        S_LOAD_B,
        S_WAIT_B,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [8:0] TMO_LAST = 9'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] period_a_q;
    logic [7:0] period_b_q;
    logic [3:0] remaining_q;
    logic [8:0] tmo_q;
    logic       load_q;
    logic [7:0] preset_q;
    logic       busy_q;
    logic       phase_q;
    logic       done_q;
    logic       err_q;

    // NOTE: every register here is written with <= so all transitions see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            period_a_q  <= 8'h00;
            period_b_q  <= 8'h00;
            remaining_q <= 4'd0;
            tmo_q       <= 9'd0;
            load_q      <= 1'b0;
            preset_q    <= 8'h00;
            busy_q      <= 1'b0;
            phase_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            period_a_q  <= bus.period_a;
                            period_b_q  <= bus.period_b;
                            remaining_q <= bus.cycles;
                            if (bus.cycles != 4'd0) begin
                                state_q  <= S_LOAD_A;
                                load_q   <= 1'b1;
                                preset_q <= bus.period_a;
                                busy_q   <= 1'b1;
                                phase_q  <= 1'b0;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_LOAD_A: begin
                        state_q <= S_WAIT_A;
                        tmo_q   <= 9'd0;
                    end
                    S_WAIT_A: begin
                        if (bus.tcount) begin
                            state_q  <= S_LOAD_B;
                            load_q   <= 1'b1;
                            preset_q <= period_b_q;
                            phase_q  <= 1'b1;
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 9'd1;
                        end
                    end
                    S_LOAD_B: begin
                        state_q <= S_WAIT_B;
                        tmo_q   <= 9'd0;
                    end
                    S_WAIT_B: begin
                        if (bus.tcount) begin
                            remaining_q <= remaining_q - 4'd1;
                            if (remaining_q == 4'd1) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= S_LOAD_A;
                                load_q   <= 1'b1;
                                preset_q <= period_a_q;
                                phase_q  <= 1'b0;
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 9'd1;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    // ERROR only leaves through the abort path above.
                    S_ERROR: state_q <= S_ERROR;
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.load   = load_q;
    assign bus.preset = preset_q;
    assign bus.busy   = busy_q;
    assign bus.phase  = phase_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_tcount_sequencer.sv
// Bench: sequencer paired with a behavioural loadable up-counter; each run is predicted
// as a per-cycle output timeline computed from the period arithmetic (256 - preset waits).
module tb_tcount_sequencer;
    localparam int TB_TIMEOUT = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tc_kill = 1'b0;
    logic [7:0] cnt = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected output vector: {load, preset[7:0], busy, phase, done, err}
    logic [12:0] exp_q[$];
    logic [12:0] last_exp;
    logic [7:0]  exp_preset = 8'h00;
    logic        exp_phase  = 1'b0;
    bit          exp_err;

    tcount_sequencer_if bus ();

    tcount_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= bus.load ? bus.preset : cnt + 8'd1;
    assign bus.tcount = (cnt == 8'hFF) && !tc_kill;

    function automatic logic [12:0] outs();
        return {bus.load, bus.preset, bus.busy, bus.phase, bus.done, bus.err};
    endfunction

    function automatic logic [12:0] idle_vec();
        return {1'b0, exp_preset, 1'b0, exp_phase, 1'b0, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Timeline model: each half-pair is one load cycle then (256 - period) wait cycles,
    // unless that exceeds TIMEOUT, in which case the run errors after TIMEOUT waits.
    task automatic build_expected(input logic [7:0] pa, input logic [7:0] pb,
                                  input logic [3:0] cyc, input bit kill);
        exp_q.delete();
        exp_err = 1'b0;
        for (int p = 0; p < int'(cyc) && !exp_err; p++) begin
            for (int h = 0; h < 2 && !exp_err; h++) begin
                logic [7:0] pv = (h == 1) ? pb : pa;
                int n = kill ? 1000 : 256 - int'(pv);
                exp_preset = pv;
                exp_phase  = h[0];
                exp_q.push_back({1'b1, pv, 1'b1, exp_phase, 1'b0, 1'b0});
                if (n > TB_TIMEOUT) begin
                    repeat (TB_TIMEOUT) exp_q.push_back({1'b0, pv, 1'b1, exp_phase, 1'b0, 1'b0});
                    exp_err = 1'b1;
                end else begin
                    repeat (n) exp_q.push_back({1'b0, pv, 1'b1, exp_phase, 1'b0, 1'b0});
                end
            end
        end
        if (exp_err) begin
            repeat (3) exp_q.push_back({1'b0, exp_preset, 1'b0, exp_phase, 1'b0, 1'b1});
        end else begin
            exp_q.push_back({1'b0, exp_preset, 1'b0, exp_phase, 1'b1, 1'b0});
            repeat (2) exp_q.push_back({1'b0, exp_preset, 1'b0, exp_phase, 1'b0, 1'b0});
        end
    endtask

    // Pulses start, then compares each predicted cycle; inputs are scrambled mid-run
    // and start is toggled randomly only while the block is busy or in error.
    task automatic run(input string tag, input logic [7:0] pa, input logic [7:0] pb,
                       input logic [3:0] cyc, input bit kill, input int stop);
        build_expected(pa, pb, cyc, kill);
        @(negedge clk);
        tc_kill      = kill;
        bus.period_a = pa;
        bus.period_b = pb;
        bus.cycles   = cyc;
        bus.start    = 1'b1;
        for (int i = 0; i < exp_q.size() && (stop < 0 || i < stop); i++) begin
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), outs(), exp_q[i]);
            last_exp     = exp_q[i];
            bus.start    = (exp_q[i][3] | exp_q[i][0]) ? 1'($urandom) : 1'b0;
            bus.period_a = 8'($urandom);
            bus.period_b = 8'($urandom);
            bus.cycles   = 4'($urandom);
        end
        bus.start = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_idle[%0d]", tag, i), outs(), idle_vec());
        end
    endtask

    task automatic abort_now(input string tag);
        exp_preset = last_exp[11:4];
        exp_phase  = last_exp[2];
        bus.start  = 1'b0;
        bus.abort  = 1'b1;
        @(negedge clk);
        check({tag, "_abort"}, outs(), idle_vec());
        bus.abort = 1'b0;
        idle_check(tag, 3);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.period_a = 8'h00;
        bus.period_b = 8'h00;
        bus.cycles   = 4'd0;

        #1 reset = 1'b0;
        #1 check("reset_state", outs(), 13'h0000);
        repeat (2) @(negedge clk);
        check("reset_held", outs(), 13'h0000);
        reset = 1'b1;
        idle_check("post_reset", 2);

        run("basic", 8'hF0, 8'hFA, 4'd1, 1'b0, -1);
        run("multi", 8'hFE, 8'hFC, 4'd3, 1'b0, -1);
        run("zero", 8'h10, 8'h20, 4'd0, 1'b0, -1);

        // tcount held low: error after TIMEOUT waits, start ignored, abort recovers.
        run("timeout", 8'hF0, 8'hF0, 4'd1, 1'b1, -1);
        bus.start = 1'b1;
        @(negedge clk);
        check("err_ignores_start", outs(), {1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1});
        last_exp = outs();
        tc_kill = 1'b0;
        abort_now("timeout");

        // tcount on the very timeout cycle wins; one cycle later it is too late.
        run("tmo_edge", 8'hEC, 8'hFF, 4'd1, 1'b0, -1);
        run("tmo_over", 8'hEB, 8'hFF, 4'd1, 1'b0, -1);
        if (exp_err) abort_now("tmo_over");

        // Abort inside WAIT_B of a two-pair run (entry 14 is a WAIT_B cycle).
        run("abort_mid", 8'hF8, 8'hF0, 4'd2, 1'b0, 15);
        abort_now("abort_mid");

        // Start and abort together in IDLE: nothing starts.
        @(negedge clk);
        bus.period_a = 8'hFE;
        bus.period_b = 8'hFE;
        bus.cycles   = 4'd1;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        @(negedge clk);
        check("start_abort", outs(), idle_vec());
        idle_check("start_abort", 3);

        // Asynchronous reset in WAIT_A, checked between clock edges.
        run("rst_mid", 8'hF0, 8'hF0, 4'd2, 1'b0, 5);
        #2 reset = 1'b0;
        #1 check("rst_async", outs(), 13'h0000);
        @(posedge clk);
        #1 check("rst_hold", outs(), 13'h0000);
        @(negedge clk);
        reset = 1'b1;
        exp_preset = 8'h00;
        exp_phase  = 1'b0;
        idle_check("rst_release", 3);

        for (int r = 0; r < 8; r++) begin
            logic [7:0] pa = 8'($urandom_range(232, 255));
            logic [7:0] pb = 8'($urandom_range(232, 255));
            logic [3:0] cy = 4'($urandom_range(0, 4));
            run($sformatf("rand%0d", r), pa, pb, cy, 1'b0, -1);
            if (exp_err) abort_now($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
